// File: rtl/isa_bus_pkg.sv
// Shared ISA bus definitions: state encoding, default I/O cycle timings and bus widths.
// Latency: n/a (constants and a compile-time helper only).
// Backpressure: n/a.
package isa_bus_pkg;

   localparam int IO_ADDR_W  = 16;
   localparam int ISA_ADDR_W = 20;

   // Default I/O cycle timing, in bus clocks (14.318 MHz)
   localparam int DEF_ADDR_SETUP    = 2;
   localparam int DEF_STROBE_CYCLES = 6;
   localparam int DEF_HOLD_CYCLES   = 2;
   localparam int DEF_RDY_TIMEOUT   = 64;

   // Initiator FSM encoding
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SETUP    = 3'd1;
   localparam logic [2:0] ST_STROBE   = 3'd2;
   localparam logic [2:0] ST_WAIT_RDY = 3'd3;
   localparam logic [2:0] ST_HOLD     = 3'd4;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/isa_cycle_timer.sv
// Loadable down-counter shared by all timed FSM states; tc_o is high while the count is zero.
// Latency: a load of N makes tc_o rise N+1 edges later (N clocks of count plus the terminal cycle).
// Backpressure: none; load_i always wins over counting.
// Ports: clk/reset (sync, active high), load_i + val_i reload the count, tc_o terminal count.
module isa_cycle_timer #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/isa_io_master.sv
// ISA I/O-cycle initiator: turns a single-beat req/ack request into timed AEN/ALE/IOR#/IOW# signalling.
// Latency: req accept to ack = 1 + ADDR_SETUP + STROBE_CYCLES + HOLD_CYCLES edges, plus IOCHRDY wait states.
// Backpressure: busy high while a cycle is in flight; req is ignored (not queued) until back in IDLE.
// Ports: request side (req/we/addr/wdata -> busy/ack/err/rdata); ISA side (bus_a, bus_aen, bus_ale,
//   bus_ior_l, bus_iow_l, bus_rdy, bus_d_in, bus_d_out, bus_d_oe). All outputs come straight from flops.
module isa_io_master
   import isa_bus_pkg::*;
#(
   parameter int ADDR_SETUP    = DEF_ADDR_SETUP,
   parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int RDY_TIMEOUT   = DEF_RDY_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  we,
   input  logic [IO_ADDR_W-1:0]  addr,
   input  logic [7:0]            wdata,
   output logic                  busy,
   output logic                  ack,
   output logic                  err,
   output logic [7:0]            rdata,
   output logic [ISA_ADDR_W-1:0] bus_a,
   output logic                  bus_aen,
   output logic                  bus_ale,
   output logic                  bus_ior_l,
   output logic                  bus_iow_l,
   input  logic                  bus_rdy,
   input  logic [7:0]            bus_d_in,
   output logic [7:0]            bus_d_out,
   output logic                  bus_d_oe
);

   localparam int CNT_W = $clog2(max4(ADDR_SETUP, STROBE_CYCLES, HOLD_CYCLES, RDY_TIMEOUT)) + 1;

   logic [2:0]            state_q, state_d;
   logic                  we_q, we_d;
   logic                  busy_q, busy_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [7:0]            rdata_q, rdata_d;
   logic [ISA_ADDR_W-1:0] a_q, a_d;
   logic                  aen_q, aen_d;
   logic                  ale_q, ale_d;
   logic                  ior_l_q, ior_l_d;
   logic                  iow_l_q, iow_l_d;
   logic [7:0]            dout_q, dout_d;
   logic                  doe_q, doe_d;

   logic                  tmr_load;
   logic [CNT_W-1:0]      tmr_val;
   logic                  tmr_tc;
   logic                  end_strobe;
   logic                  timed_out;

   isa_cycle_timer #(.W(CNT_W)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load_i (tmr_load),
      .val_i  (tmr_val),
      .tc_o   (tmr_tc)
   );

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      busy_d     = busy_q;
      ack_d      = ack_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      a_d        = a_q;
      aen_d      = aen_q;
      ale_d      = ale_q;
      ior_l_d    = ior_l_q;
      iow_l_d    = iow_l_q;
      dout_d     = dout_q;
      doe_d      = doe_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      end_strobe = 1'b0;
      timed_out  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ack_d  = 1'b0;
            busy_d = 1'b0;
            if (req) begin
               we_d     = we;
               busy_d   = 1'b1;
               err_d    = 1'b0;
               a_d      = {{(ISA_ADDR_W-IO_ADDR_W){1'b0}}, addr};
               aen_d    = 1'b0;
               ale_d    = 1'b1;
               doe_d    = we;
               dout_d   = wdata;
               state_d  = ST_SETUP;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(ADDR_SETUP - 1);
            end
         end
         ST_SETUP: begin
            // ALE is a single-cycle address latch pulse at the start of SETUP
            ale_d = 1'b0;
            if (tmr_tc) begin
               ior_l_d  = we_q;
               iow_l_d  = ~we_q;
               state_d  = ST_STROBE;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(STROBE_CYCLES - 1);
            end
         end
         ST_STROBE: begin
            if (tmr_tc) begin
               if (bus_rdy) begin
                  end_strobe = 1'b1;
               end else begin
                  state_d  = ST_WAIT_RDY;
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(RDY_TIMEOUT - 1);
               end
            end
         end
         ST_WAIT_RDY: begin
            if (bus_rdy) begin
               end_strobe = 1'b1;
            end else if (tmr_tc) begin
               end_strobe = 1'b1;
               timed_out  = 1'b1;
            end
         end
         ST_HOLD: begin
            if (tmr_tc) begin
               aen_d   = 1'b1;
               doe_d   = 1'b0;
               ack_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Strobe rise: read data is captured on this edge, including a timeout abort
      if (end_strobe) begin
         ior_l_d  = 1'b1;
         iow_l_d  = 1'b1;
         if (!we_q) rdata_d = bus_d_in;
         if (timed_out) err_d = 1'b1;
         state_d  = ST_HOLD;
         tmr_load = 1'b1;
         tmr_val  = CNT_W'(HOLD_CYCLES - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         a_q     <= '0;
         aen_q   <= 1'b1;
         ale_q   <= 1'b0;
         ior_l_q <= 1'b1;
         iow_l_q <= 1'b1;
         dout_q  <= '0;
         doe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         a_q     <= a_d;
         aen_q   <= aen_d;
         ale_q   <= ale_d;
         ior_l_q <= ior_l_d;
         iow_l_q <= iow_l_d;
         dout_q  <= dout_d;
         doe_q   <= doe_d;
      end
   end

   assign busy      = busy_q;
   assign ack       = ack_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign bus_a     = a_q;
   assign bus_aen   = aen_q;
   assign bus_ale   = ale_q;
   assign bus_ior_l = ior_l_q;
   assign bus_iow_l = iow_l_q;
   assign bus_d_out = dout_q;
   assign bus_d_oe  = doe_q;

endmodule
